// File: rtl/accum_warp_looper_nd.sv
// accum_warp_looper_nd: walks a DIM-deep nested loop with stencil taps innermost, emitting one address beat per warp
module accum_warp_looper_nd #(
  parameter int DIM     = 3,
  parameter int AW      = 16,
  parameter int CW      = 8,
  parameter int STENCIL = 1,
  parameter int NSTEN   = 4,
  parameter int TW      = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_abofs_rdy,
  output logic                o_abofs_ack,
  input  logic [AW-1:0]       i_bofs,
  input  logic [DIM*CW-1:0]   i_bound,
  input  logic [DIM*AW-1:0]   i_stride,
  input  logic [TW-1:0]       i_nsten,
  input  logic [NSTEN*AW-1:0] i_sten_ofs,
  output logic                o_addrval_rdy,
  input  logic                i_addrval_ack,
  output logic [AW-1:0]       o_addr,
  output logic [DIM*CW-1:0]   o_idx,
  output logic [TW-1:0]       o_tap,
  output logic                o_last
);
  localparam int NT = 1 << TW;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [DIM-1:0][CW-1:0] bound, idx, nidx;
  logic [DIM-1:0][AW-1:0] stride, base;
  logic [DIM:0][AW-1:0] nb;
  logic [NT-1:0][AW-1:0] ofs, ofs_in;
  logic [TW-1:0] nsten, nsten_in, tap, ntap;
  logic [DIM:0] c;
  logic [DIM-1:0] wrap, wrap_n, one_in;
  logic empty, last0, nlast;
  assign ofs_in = (STENCIL != 0) ? {{((NT-NSTEN)*AW){1'b0}}, i_sten_ofs} : '0;
  assign nsten_in = (STENCIL != 0) ? i_nsten : TW'(1);
  assign o_abofs_ack = i_abofs_rdy && state == IDLE && !i_rst;
  assign o_addrval_rdy = state == RUN;
  assign o_idx = idx;
  assign o_tap = tap;
  // next position: carry chain from the tap up through the dims, running bases reloaded below the carrying dim
  always_comb begin
    c = '0;
    nb = '0;
    empty = (STENCIL != 0) && i_nsten == '0;
    c[0] = tap == nsten - TW'(1);
    for (int d = 0; d < DIM; d++) begin
      wrap[d] = idx[d] == bound[d] - CW'(1);
      c[d+1] = c[d] && wrap[d];
      nidx[d] = c[d] ? (wrap[d] ? '0 : idx[d] + CW'(1)) : idx[d];
      wrap_n[d] = nidx[d] == bound[d] - CW'(1);
      one_in[d] = i_bound[d*CW +: CW] == CW'(1);
      if (i_bound[d*CW +: CW] == '0) empty = 1'b1;
    end
    for (int d = DIM-1; d >= 0; d--)
      nb[d] = (c[d] && !wrap[d]) ? base[d] + stride[d] : c[d] ? nb[d+1] : base[d];
    ntap = c[0] ? '0 : tap + TW'(1);
    nlast = ntap == nsten - TW'(1) && &wrap_n;
    last0 = nsten_in == TW'(1) && &one_in;
  end
  // descriptor capture, beat advance on each consumed beat, return to idle after the last beat
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_addr <= '0;
      idx <= '0;
      tap <= '0;
      o_last <= 1'b0;
    end else if (o_abofs_ack && !empty) begin
      state <= RUN;
      bound <= i_bound;
      stride <= i_stride;
      nsten <= nsten_in;
      ofs <= ofs_in;
      base <= {DIM{i_bofs}};
      idx <= '0;
      tap <= '0;
      o_addr <= i_bofs + ofs_in[0];
      o_last <= last0;
    end else if (state == RUN && i_addrval_ack) begin
      if (o_last) begin
        state <= IDLE;
        o_last <= 1'b0;
      end else begin
        idx <= nidx;
        tap <= ntap;
        base <= nb[DIM-1:0];
        o_addr <= nb[0] + ofs[ntap];
        o_last <= nlast;
      end
    end
  end
endmodule

// File: tb/tb_accum_warp_looper_nd.sv
// tb_accum_warp_looper_nd: scoreboard bench with a mixed-radix reference model of the beat stream
module tb_accum_warp_looper_nd;
  localparam int DIM = 3, AW = 16, CW = 8, NSTEN = 4, TW = 3;
  logic i_clk = 0, i_rst = 1, i_abofs_rdy = 0, i_addrval_ack = 0;
  logic [AW-1:0] i_bofs = '0;
  logic [DIM*CW-1:0] i_bound = '0;
  logic [DIM*AW-1:0] i_stride = '0;
  logic [TW-1:0] i_nsten = '0;
  logic [NSTEN*AW-1:0] i_sten_ofs = '0;
  logic o_abofs_ack, o_addrval_rdy, o_last;
  logic [AW-1:0] o_addr;
  logic [DIM*CW-1:0] o_idx;
  logic [TW-1:0] o_tap;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DIM*CW-1:0] idx;
    logic [TW-1:0] tap;
    logic last;
  } beat_t;
  beat_t q[$];
  int checks = 0, failures = 0, beats = 0, ack_pct = 100;
  localparam logic [DIM*CW-1:0] S1B = {8'd2, 8'd3, 8'd4};
  localparam logic [DIM*AW-1:0] S1S = {16'h100, 16'h10, 16'h1};

  accum_warp_looper_nd dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_abofs_rdy(i_abofs_rdy), .o_abofs_ack(o_abofs_ack),
    .i_bofs(i_bofs), .i_bound(i_bound), .i_stride(i_stride), .i_nsten(i_nsten),
    .i_sten_ofs(i_sten_ofs), .o_addrval_rdy(o_addrval_rdy), .i_addrval_ack(i_addrval_ack),
    .o_addr(o_addr), .o_idx(o_idx), .o_tap(o_tap), .o_last(o_last)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_block(input logic [AW-1:0] b, input logic [DIM*CW-1:0] bd,
                            input logic [DIM*AW-1:0] st, input logic [TW-1:0] ns,
                            input logic [NSTEN*AW-1:0] so);
    int total = int'(ns);
    for (int d = 0; d < DIM; d++) total *= int'(bd[d*CW +: CW]);
    for (int n = 0; n < total; n++) begin
      beat_t e;
      int t = n % int'(ns);
      int r = n / int'(ns);
      e.addr = b + so[t*AW +: AW];
      e.idx = '0;
      for (int d = 0; d < DIM; d++) begin
        int i = r % int'(bd[d*CW +: CW]);
        r = r / int'(bd[d*CW +: CW]);
        e.idx[d*CW +: CW] = CW'(i);
        e.addr = e.addr + AW'(i * int'(st[d*AW +: AW]));
      end
      e.tap = TW'(t);
      e.last = n == total - 1;
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [AW-1:0] b, input logic [DIM*CW-1:0] bd,
                      input logic [DIM*AW-1:0] st, input logic [TW-1:0] ns,
                      input logic [NSTEN*AW-1:0] so, output int w, output logic r0);
    i_bofs = b;
    i_bound = bd;
    i_stride = st;
    i_nsten = ns;
    i_sten_ofs = so;
    i_abofs_rdy = 1;
    w = 0;
    @(negedge i_clk);
    r0 = o_addrval_rdy;
    while (!o_abofs_ack && w < 5000) begin
      w++;
      @(negedge i_clk);
    end
    check("desc_ack", 64'(o_abofs_ack), 64'd1);
    if (o_abofs_ack) push_block(b, bd, st, ns, so);
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while ((q.size() != 0 || o_addrval_rdy) && n < 20000);
    check("drain", 64'(q.size()), 64'd0);
    @(posedge i_clk);
    #1;
  endtask

  initial forever begin
    @(posedge i_clk);
    #1;
    i_addrval_ack = $urandom_range(0, 99) < ack_pct;
  end

  initial begin
    logic pend = 0, prev_rst = 1;
    beat_t prev, got;
    forever begin
      @(negedge i_clk);
      got = {o_addr, o_idx, o_tap, o_last};
      if (o_addrval_rdy) check("no_ack_in_run", 64'(o_abofs_ack), 64'd0);
      if (pend && !prev_rst) check("hold", {got, o_addrval_rdy}, {prev, 1'b1});
      if (o_addrval_rdy && i_addrval_ack) begin
        if (q.size() == 0) check("unexpected_beat", 64'(got), 64'hDEAD_BEEF_0000);
        else check("beat", 64'(got), 64'(q.pop_front()));
        beats++;
      end
      pend = o_addrval_rdy && !i_addrval_ack;
      prev = got;
      prev_rst = i_rst;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, b0, n;
    logic r, r2;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_rdy", 64'(o_addrval_rdy), 0);
    check("rst_ack", 64'(o_abofs_ack), 0);
    check("rst_out", {o_addr, o_idx, o_tap, o_last}, 0);
    @(posedge i_clk);
    #1;
    i_rst = 0;
    b0 = beats;
    send(16'h100, S1B, S1S, 3'd1, '0, w, r);
    i_abofs_rdy = 0;
    drain();
    check("s1_beats", 64'(beats - b0), 64'd24);
    b0 = beats;
    send(16'h20, {8'd1, 8'd1, 8'd2}, {16'h0, 16'h0, 16'h10}, 3'd3,
         {16'h0, 16'h1, 16'h0, 16'hFFFF}, w, r);
    i_abofs_rdy = 0;
    drain();
    check("s2_beats", 64'(beats - b0), 64'd6);
    ack_pct = 30;
    b0 = beats;
    send(16'h100, S1B, S1S, 3'd1, '0, w, r);
    i_abofs_rdy = 0;
    drain();
    check("s3_beats", 64'(beats - b0), 64'd24);
    ack_pct = 100;
    send(16'h40, {8'd2, 8'd0, 8'd3}, S1S, 3'd1, '0, w, r);
    send(16'h100, S1B, S1S, 3'd1, '0, w2, r2);
    i_abofs_rdy = 0;
    check("empty_rdy", 64'(r2), 0);
    check("empty_next_wait", 64'(w2), 0);
    drain();
    send(16'hFFFE, {8'd1, 8'd1, 8'd4}, {16'h0, 16'h0, 16'h1}, 3'd1, '0, w, r);
    i_abofs_rdy = 0;
    drain();
    b0 = beats;
    send(16'h100, S1B, S1S, 3'd1, '0, w, r);
    i_abofs_rdy = 0;
    n = 0;
    while (beats < b0 + 5 && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    check("s6_pre_beats", 64'(beats >= b0 + 5), 64'd1);
    @(posedge i_clk);
    #1;
    i_rst = 1;
    @(posedge i_clk);
    #1;
    i_bofs = 16'h300;
    i_abofs_rdy = 1;
    @(negedge i_clk);
    check("s6_rdy_low", 64'(o_addrval_rdy), 0);
    check("s6_rst_ack", 64'(o_abofs_ack), 0);
    q.delete();
    @(posedge i_clk);
    #1;
    i_rst = 0;
    i_abofs_rdy = 0;
    @(negedge i_clk);
    check("s6_not_taken", 64'(o_addrval_rdy), 0);
    @(posedge i_clk);
    #1;
    b0 = beats;
    send(16'h100, S1B, S1S, 3'd1, '0, w, r);
    i_abofs_rdy = 0;
    drain();
    check("s6_beats", 64'(beats - b0), 64'd24);
    for (int k = 0; k < 40; k++) begin
      logic [DIM*CW-1:0] bd;
      logic [DIM*AW-1:0] st;
      logic [NSTEN*AW-1:0] so;
      for (int d = 0; d < DIM; d++) begin
        bd[d*CW +: CW] = CW'($urandom_range(0, 4));
        st[d*AW +: AW] = AW'($urandom);
      end
      for (int t = 0; t < NSTEN; t++) so[t*AW +: AW] = AW'($urandom);
      ack_pct = $urandom_range(30, 100);
      send(AW'($urandom), bd, st, TW'($urandom_range(0, 4)), so, w, r);
    end
    i_abofs_rdy = 0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/accum_warp_looper_nd.md
Name: accum_warp_looper_nd

Overview:
Parametrised successor to the fixed 2-level accumulation warp looper. It accepts one block descriptor per rdy/ack handshake: base offset, per-dimension loop bounds and strides, and an optional stencil tap list. It then walks a DIM-deep nested loop with the stencil taps innermost, emitting one address beat per warp over an addrval rdy/ack stream. It sits between the block dispatcher and the accumulator read path.

Parameters:
DIM, 3, number of loop dimensions (1..4); dim 0 is innermost.
AW, 16, address width; all address arithmetic is modulo 2^AW.
CW, 8, loop-count width per dimension.
STENCIL, 1, 1 = stencil tap loop enabled; 0 = taps ignored, treated as nsten=1, offset 0.
NSTEN, 4, maximum stencil taps.
TW, 3, tap-count width; must satisfy 2^TW > NSTEN.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_abofs_rdy  in  1  block descriptor valid
o_abofs_ack  out  1  descriptor accepted
i_bofs  in  AW  block base address
i_bound  in  DIM*CW  loop count per dimension; slice d is dimension d
i_stride  in  DIM*AW  unsigned address stride per dimension
i_nsten  in  TW  number of taps (1..NSTEN)
i_sten_ofs  in  NSTEN*AW  two's-complement tap offsets
o_addrval_rdy  out  1  beat valid
i_addrval_ack  in  1  beat consumed
o_addr  out  AW  beat address
o_idx  out  DIM*CW  current loop indices
o_tap  out  TW  current tap index
o_last  out  1  final beat of the block

Behaviour:
- Handshake convention: a transfer occurs in a cycle where rdy && ack. Ack may depend combinationally on rdy. rdy must never depend combinationally on ack.
- FSM has two states, IDLE and RUN.
- Descriptor acceptance: o_abofs_ack = i_abofs_rdy && state==IDLE. On transfer, latch bofs, bound, stride, nsten and sten_ofs.
- Empty block: if any bound slice == 0, or (STENCIL && nsten == 0), the descriptor is acked, no beats are emitted, and the FSM stays in IDLE.
- Otherwise the FSM enters RUN next cycle with idx = 0, tap = 0 and o_addr = bofs + sten_ofs[0].
- In RUN, o_addrval_rdy = 1, driven from state (registered).
- While a beat is unacked, o_addr, o_idx, o_tap and o_last hold stable.
- Beat order: tap fastest, then idx[0], ..., idx[DIM-1] slowest. Total beats = product(bound) * nsten.
- Address of a beat = bofs + sum_d idx[d]*stride[d] + sten_ofs[tap], mod 2^AW; sten_ofs is sign-extended.
- Address must be produced without multipliers, using per-dimension running-base registers:
  - on carry out of dimension d, reload the base of dims < d from the base of dim d, then add stride[d];
  - result must be bit-exact to the formula above.
- o_last = 1 exactly when tap == nsten-1 and idx[d] == bound[d]-1 for all d.
- On the transfer of the o_last beat the FSM returns to IDLE. A new descriptor can be acked no earlier than the following cycle (one-cycle bubble between blocks).
- Width rules: bound up to 2^CW-1. Indices never exceed bound-1. Address wraps silently.
- Reset values: state IDLE; o_addrval_rdy 0, o_abofs_ack 0 (i_abofs_rdy gated by state), o_addr 0, o_idx 0, o_tap 0, o_last 0.
- Reset mid-block: the current block is abandoned. o_addrval_rdy is 0 in the cycle after i_rst is sampled high, and no beat of the old block is emitted afterwards.
- Reset taking precedence: i_rst high together with a pending descriptor leaves the descriptor unaccepted.

Test Plan:
1. DIM=3, bofs=0x100, bound{d0=4,d1=3,d2=2}, stride{1,0x10,0x100}, nsten=1, ofs 0, ack held 1 -> 24 consecutive beats. Addresses run 0x100..0x103, 0x110.., ending 0x223. o_last only on the beat with address 0x223. Then IDLE.
2. Stencil: bofs=0x20, bound{2,1,1}, stride d0=0x10, nsten=3, ofs{-1,0,+1} -> addrs 0x1F,0x20,0x21,0x2F,0x30,0x31; o_tap 0,1,2,0,1,2; o_last on beat 6.
3. Backpressure: scenario 1 with i_addrval_ack random at 30% -> identical sequence; outputs never change while rdy && !ack; no beat dropped or duplicated.
4. Zero bound (d1=0) -> o_abofs_ack pulses and o_addrval_rdy stays 0. A following valid descriptor is acked on the next cycle and streams normally.
5. Wraparound: bofs=0xFFFE, bound{4,1,1}, stride 1 -> 0xFFFE, 0xFFFF, 0x0000, 0x0001.
6. i_rst asserted after 5 acked beats of scenario 1 -> rdy low the cycle after reset is sampled. After release, a new descriptor restarts at idx 0 with address bofs.
